// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   PC_WIDTH      : width of program-counter and instruction-memory addresses
//   NOP_INST      : instruction word driven to IF/ID whenever nothing is delivered
//   fetch_state_t : fetch-stage sequencing states
package if_fetch_stage_pkg;

    localparam int unsigned PC_WIDTH = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // first cycle after reset release, emits a bubble
        ST_FETCH = 2'd1,  // request outstanding at pc
        ST_HOLD  = 2'd2,  // response captured while ID is stalled
        ST_DRAIN = 2'd3   // waiting to discard a wrong-path response
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_hold_buf.sv
// Capture register for a response that arrives while ID is stalled.
// Holds {pc+4, inst} until the stall releases or a redirect discards it.
//   clk    : clock, rising edge
//   init_n : asynchronous active-low reset, clears contents
//   load   : capture d on the next rising edge
//   clear  : zero contents on the next rising edge (wins over load)
//   d      : data to capture
//   q      : captured data
module if_hold_buf #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, drives the instruction-memory handshake, applies ID redirects
// and load-use stalls, and produces the IF/ID write bundle each cycle.
//   clk, init_n         : clock (rising edge), async active-low reset
//   stall               : hold IF and IF/ID (load-use hazard)
//   redirect_valid/_pc  : taken branch/jump from ID; target low two bits ignored
//   imem_req/_addr      : fetch request and address (current PC)
//   imem_ready/_rdata   : response valid and instruction word
//   pc_out, inst_out    : delivered PC+4 and instruction to IF/ID
//   if_id_we, if_flush  : IF/ID write enable and bubble insertion
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = 32'd4
) (
    input  logic                clk,
    input  logic                init_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [31:0]         inst_out,
    output logic                if_id_we,
    output logic                if_flush
);

    fetch_state_t        state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next, pc_plus4;
    logic                buf_load, buf_clear;
    logic [63:0]         buf_q;
    logic                req_c, we_c, flush_c;
    logic [PC_WIDTH-1:0] pc_out_c;
    logic [31:0]         inst_c;

    assign pc_plus4 = pc + 32'd4;

    if_hold_buf #(.WIDTH(64)) u_hold_buf (
        .clk    (clk),
        .init_n (init_n),
        .load   (buf_load),
        .clear  (buf_clear),
        .d      ({pc_plus4, imem_rdata}),
        .q      (buf_q)
    );

    always_comb begin
        state_next = state;
        pc_next    = pc;
        req_c      = 1'b0;
        we_c       = 1'b0;
        flush_c    = 1'b0;
        pc_out_c   = '0;
        inst_c     = NOP_INST;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        if (redirect_valid) begin
            // Redirect beats stall and any delivery; a request left without
            // a response must be drained before the new path is fetched.
            req_c     = (state == ST_FETCH);
            we_c      = 1'b1;
            flush_c   = 1'b1;
            pc_next   = redirect_pc & ~32'h3;
            buf_clear = 1'b1;
            if ((state == ST_FETCH || state == ST_DRAIN) && !imem_ready) begin
                state_next = ST_DRAIN;
            end else begin
                state_next = ST_FETCH;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    we_c       = 1'b1;
                    flush_c    = 1'b1;
                    state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    req_c = 1'b1;
                    if (imem_ready && !stall) begin
                        we_c     = 1'b1;
                        pc_out_c = pc_plus4;
                        inst_c   = imem_rdata;
                        pc_next  = pc + PC_STEP;
                    end else if (imem_ready) begin
                        buf_load   = 1'b1;
                        state_next = ST_HOLD;
                    end else if (!stall) begin
                        we_c    = 1'b1;
                        flush_c = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        we_c       = 1'b1;
                        pc_out_c   = buf_q[63:32];
                        inst_c     = buf_q[31:0];
                        pc_next    = pc + PC_STEP;
                        state_next = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    we_c    = !stall;
                    flush_c = 1'b1;
                    if (imem_ready) begin
                        state_next = ST_FETCH;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted, not just after the
    // state register has been cleared, so the IF/ID register sees no write.
    assign imem_req  = init_n & req_c;
    assign imem_addr = pc;
    assign if_id_we  = init_n & we_c;
    assign if_flush  = init_n & flush_c;
    assign pc_out    = init_n ? pc_out_c : '0;
    assign inst_out  = init_n ? inst_c : NOP_INST;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

endmodule
